// File: rtl/tone_detector.sv
// Alarm-buzzer tone detector: measures tone_in half-periods and locks onto a low (1 kHz) or high (2 kHz) tone.
// Optional build macro TONE_DEGLITCH_EN inserts a 3-sample majority filter after the synchroniser.
module tone_detector #(
  parameter int HALF_LO  = 50000,
  parameter int HALF_HI  = 25000,
  parameter int TOL      = 1000,
  parameter int LOCK_CNT = 4,
  parameter int TIMEOUT  = 100000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        tone_in,
  output logic [1:0]  tone_code,
  output logic        tone_valid,
  output logic        tone_change,
  output logic [27:0] half_period
);

  localparam int RW = (LOCK_CNT < 1) ? 1 : $clog2(LOCK_CNT + 1);
  localparam logic [RW-1:0] RUN_MAX    = RW'(LOCK_CNT);
  localparam logic [27:0]   LO_W       = 28'(HALF_LO);
  localparam logic [27:0]   HI_W       = 28'(HALF_HI);
  localparam logic [27:0]   TOL_W      = 28'(TOL);
  localparam logic [27:0]   TIMEOUT_W  = 28'(TIMEOUT);
  localparam logic [27:0]   TIMEOUT_M1 = 28'(TIMEOUT - 1);
  localparam logic [1:0]    CLS_NONE   = 2'b00;
  localparam logic [1:0]    CLS_LO     = 2'b01;
  localparam logic [1:0]    CLS_HI     = 2'b10;

  typedef enum logic [1:0] {IDLE = 2'd0, ARMED = 2'd1, MEASURE = 2'd2, LOCKED = 2'd3} state_t;

  // Class codes double as tone_code values, so a lock copies the class straight out.
  function automatic logic [1:0] classify(input logic [27:0] m);
    logic [27:0] d_lo;
    logic [27:0] d_hi;
    d_lo = (m >= LO_W) ? (m - LO_W) : (LO_W - m);
    d_hi = (m >= HI_W) ? (m - HI_W) : (HI_W - m);
    if (d_lo <= TOL_W) begin
      classify = CLS_LO;
    end else if (d_hi <= TOL_W) begin
      classify = CLS_HI;
    end else begin
      classify = CLS_NONE;
    end
  endfunction

  logic          sync1_r, sync2_r, prev_r;
  logic          clean_s, edge_s, timeout_s;
  logic [27:0]   gap_r, measure_s, hp_n;
  logic [1:0]    cls_s, prev_cls_r, prev_cls_n, code_n;
  logic [RW-1:0] run_r, run_n, run_calc_s;
  logic          valid_n;
  state_t        state_r, state_n;

  // Two-flop synchroniser for the asynchronous buzzer input.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r <= 1'b0;
      sync2_r <= 1'b0;
    end else begin
      sync1_r <= tone_in;
      sync2_r <= sync1_r;
    end
  end

`ifdef TONE_DEGLITCH_EN
  function automatic logic majority3(input logic a, input logic b, input logic c);
    majority3 = (a & b) | (a & c) | (b & c);
  endfunction

  logic maj_h0_r, maj_h1_r, filt_r;

  // Majority vote over three samples rejects single-cycle pulses.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      maj_h0_r <= 1'b0;
      maj_h1_r <= 1'b0;
      filt_r   <= 1'b0;
    end else begin
      maj_h0_r <= sync2_r;
      maj_h1_r <= maj_h0_r;
      filt_r   <= majority3(sync2_r, maj_h0_r, maj_h1_r);
    end
  end

  assign clean_s = filt_r;
`else
  assign clean_s = sync2_r;
`endif

  assign edge_s     = clean_s ^ prev_r;
  assign measure_s  = gap_r + 28'd1;
  assign cls_s      = classify(measure_s);
  assign timeout_s  = !edge_s && (gap_r == TIMEOUT_M1);
  assign run_calc_s = (cls_s == CLS_NONE)   ? {RW{1'b0}} :
                      (cls_s != prev_cls_r) ? RW'(1)     :
                      (run_r == RUN_MAX)    ? RUN_MAX    : (run_r + RW'(1));

  // Edge-detect copy and saturating gap counter.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_r <= 1'b0;
      gap_r  <= 28'd0;
    end else begin
      prev_r <= clean_s;
      if (edge_s) begin
        gap_r <= 28'd0;
      end else if (gap_r < TIMEOUT_W) begin
        gap_r <= gap_r + 28'd1;
      end else begin
        gap_r <= gap_r;
      end
    end
  end

  // Next-state and next-output logic; an edge takes priority over a timeout.
  always_comb begin
    state_n    = state_r;
    run_n      = run_r;
    prev_cls_n = prev_cls_r;
    code_n     = tone_code;
    valid_n    = tone_valid;
    hp_n       = half_period;
    if (edge_s) begin
      case (state_r)
        IDLE: begin
          state_n    = ARMED;
          run_n      = {RW{1'b0}};
          prev_cls_n = CLS_NONE;
        end
        ARMED, MEASURE: begin
          hp_n       = measure_s;
          run_n      = run_calc_s;
          prev_cls_n = cls_s;
          if (run_calc_s == RUN_MAX) begin
            state_n = LOCKED;
            code_n  = cls_s;
            valid_n = 1'b1;
          end else begin
            state_n = MEASURE;
          end
        end
        LOCKED: begin
          hp_n       = measure_s;
          run_n      = run_calc_s;
          prev_cls_n = cls_s;
          if ((cls_s == prev_cls_r) && (cls_s != CLS_NONE)) begin
            state_n = LOCKED;
          end else begin
            state_n = MEASURE;
            code_n  = CLS_NONE;
            valid_n = 1'b0;
          end
        end
        default: begin
          state_n    = IDLE;
          run_n      = {RW{1'b0}};
          prev_cls_n = CLS_NONE;
          code_n     = CLS_NONE;
          valid_n    = 1'b0;
        end
      endcase
    end else if (timeout_s) begin
      state_n    = IDLE;
      run_n      = {RW{1'b0}};
      prev_cls_n = CLS_NONE;
      code_n     = CLS_NONE;
      valid_n    = 1'b0;
    end else begin
      state_n = state_r;
    end
  end

  // State, run tracking and registered outputs.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= IDLE;
      run_r       <= {RW{1'b0}};
      prev_cls_r  <= CLS_NONE;
      tone_code   <= CLS_NONE;
      tone_valid  <= 1'b0;
      tone_change <= 1'b0;
      half_period <= 28'd0;
    end else begin
      state_r     <= state_n;
      run_r       <= run_n;
      prev_cls_r  <= prev_cls_n;
      tone_code   <= code_n;
      tone_valid  <= valid_n;
      tone_change <= (code_n != tone_code);
      half_period <= hp_n;
    end
  end

endmodule

// File: doc/tone_detector.md
TONE_DETECTOR -- requirements
Module: tone_detector

Interface
REQ-001 SHALL have parameter HALF_LO, default 50000: nominal half-period in clk cycles of the low (1 kHz) alarm tone.
REQ-002 SHALL have parameter HALF_HI, default 25000: nominal half-period in clk cycles of the high (2 kHz) alarm tone.
REQ-003 SHALL have parameter TOL, default 1000: allowed deviation in cycles, inclusive, around each nominal value.
REQ-004 SHALL have parameter LOCK_CNT, default 4: number of consecutive same-class half-periods required to lock.
REQ-005 SHALL have parameter TIMEOUT, default 100000: cycles with no edge after which the tone is declared absent.
REQ-006 SHALL have port clk, input, 1: the single system clock; all logic on its rising edge.
REQ-007 SHALL have port rst_n, input, 1: asynchronous, active-low reset.
REQ-008 SHALL have port tone_in, input, 1: buzzer square wave, asynchronous to clk.
REQ-009 SHALL have port tone_code, output, 2: 00 none, 01 low tone, 10 high tone; 11 is never driven.
REQ-010 SHALL have port tone_valid, output, 1: high while in LOCKED.
REQ-011 SHALL have port tone_change, output, 1: one-cycle pulse on every change of tone_code.
REQ-012 SHALL have port half_period, output, 28: last measured half-period in cycles.

Function
REQ-013 SHALL synchronise tone_in through two flip-flops, then detect both rising and falling edges against a third registered copy.
REQ-014 SHALL run a 28-bit gap counter that clears to 0 on each edge cycle, otherwise increments and saturates at TIMEOUT.
REQ-015 SHALL, on each edge, set measure = gap counter + 1, the clk cycles since the previous edge, and load it into half_period.
REQ-016 SHALL classify measure as LO if |measure-HALF_LO|<=TOL, else HI if |measure-HALF_HI|<=TOL, else OTHER; comparisons unsigned, no wrap.
REQ-017 SHALL implement states IDLE, ARMED, MEASURE and LOCKED.
REQ-018 IDLE: the first edge moves the block to ARMED and is not measured; half_period is unchanged.
REQ-019 ARMED/MEASURE: on each edge, the run counter goes to run+1 if class equals the previous class and is not OTHER, otherwise to 1 (0 for OTHER).
REQ-020 SHALL enter LOCKED when the run reaches LOCK_CNT, setting tone_code to the class and tone_valid=1 on the cycle after that edge, with tone_change pulsing in the same cycle.
REQ-021 LOCKED: a matching-class edge SHALL hold the state; a non-matching edge SHALL go to MEASURE with tone_valid=0, tone_code=00, tone_change pulse, and the run restarted per REQ-019.
REQ-022 Any state: when the gap counter reaches TIMEOUT-1 with no edge, the block SHALL go to IDLE, set tone_code=00 and tone_valid=0, and pulse tone_change only if tone_code was non-zero.
REQ-023 An edge and a timeout in the same cycle SHALL resolve as the edge.
REQ-024 Edge-to-output latency SHALL be 3 sync/detect cycles plus 1 register cycle.
REQ-025 The run counter SHALL saturate at LOCK_CNT.

Reset
REQ-026 rst_n low SHALL immediately force state IDLE, tone_code=00, tone_valid=0, tone_change=0, half_period=0, and clear the gap counter, run counter and synchroniser flops to 0.
REQ-027 Reset asserted mid-measurement SHALL discard all partial runs; the first edge after release SHALL be treated as unmeasured.

Configuration
REQ-028 With TONE_DEGLITCH_EN defined, a 3-sample majority filter SHALL follow the synchroniser, adding 2 cycles of latency and rejecting single-cycle pulses on tone_in.
REQ-029 Without TONE_DEGLITCH_EN, the synchroniser output SHALL feed edge detection directly, and every synchronised transition counts as an edge.

Verification (bench params HALF_LO=50, HALF_HI=25, TOL=2, LOCK_CNT=4, TIMEOUT=120)
REQ-030 A square wave with half-period 50 -> tone_code=01, tone_valid=1, one tone_change pulse after the 5th edge; half_period=50.
REQ-031 A locked low tone switched to half-period 25 -> tone_valid drops at the first 25-gap edge, then relocks to 10 after 4 matching gaps; two tone_change pulses total.
REQ-032 A locked tone with tone_in held static -> tone_code=00 and tone_valid=0 exactly 120 cycles after the last edge plus latency; one tone_change pulse.
REQ-033 Half-periods alternating 50/37 -> never locks, tone_valid stays 0, and half_period tracks each gap.
REQ-034 rst_n pulsed low after 3 matching gaps -> outputs zero immediately; 4 more gaps are still not enough to lock, and lock occurs on the 5th gap.
REQ-035 A 1-cycle glitch inserted mid-half-period -> with TONE_DEGLITCH_EN the lock is held; without it the lock is lost and tone_change pulses.
